// File: rtl/issue_ordered_resource_pool.sv
// issue_ordered_resource_pool
// Shares NUM_UNITS identical resources among NUM_PORTS requesters using per-unit locks.
// Free units go to the oldest pending issue IDs first. Age is compared modulo
// 2^ID_WIDTH, and ties go to the lower port index. Several grants can be made in one
// cycle. A rollback flush frees every owner that is younger than the boundary ID.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   port_req          per-port level request; held high to keep the unit
//   port_issue_id     per-port issue ID, stable while port_req is high
//   port_release      per-port single-cycle release pulse
//   flush_valid       rollback pulse
//   flush_issue_id    flush boundary ID; strictly younger owners/requesters are killed
//   port_grant        per-port "owns a unit" (registered)
//   port_unit         per-port index of the owned unit (registered, 0 when not granted)
//   busy_count        number of locked units (registered)
//   lock_error        sticky flag: release seen from a port without a grant
module issue_ordered_resource_pool #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned ID_WIDTH  = 16,
    localparam int unsigned UIDX_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int unsigned CNT_W    = $clog2(NUM_UNITS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  port_req,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]    port_issue_id,
    input  logic [NUM_PORTS-1:0]                  port_release,
    input  logic                                  flush_valid,
    input  logic [ID_WIDTH-1:0]                   flush_issue_id,
    output logic [NUM_PORTS-1:0]                  port_grant,
    output logic [NUM_PORTS-1:0][UIDX_W-1:0]      port_unit,
    output logic [CNT_W-1:0]                      busy_count,
    output logic                                  lock_error
);

    localparam int unsigned OIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // A is older than B when (A - B) mod 2^ID_WIDTH has its MSB set.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                      input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    logic [NUM_UNITS-1:0]                  unit_locked_q, unit_locked_d;
    logic [NUM_UNITS-1:0][OIDX_W-1:0]      unit_owner_q, unit_owner_d;
    logic [NUM_UNITS-1:0][ID_WIDTH-1:0]    unit_id_q, unit_id_d;
    logic [NUM_PORTS-1:0]                  port_grant_q, port_grant_d;
    logic [NUM_PORTS-1:0][UIDX_W-1:0]      port_unit_q, port_unit_d;
    logic [CNT_W-1:0]                      busy_count_q, busy_count_d;
    logic                                  lock_error_q, lock_error_d;

    logic [NUM_PORTS-1:0]                  port_free;
    logic [NUM_PORTS-1:0]                  cand;
    logic [NUM_PORTS-1:0]                  alloc_port;
    logic [NUM_PORTS-1:0][UIDX_W-1:0]      alloc_unit;
    logic [NUM_UNITS-1:0]                  unit_free;
    logic [NUM_UNITS-1:0]                  unit_alloc;
    logic [NUM_UNITS-1:0]                  avail;
    logic [NUM_PORTS-1:0]                  remaining;
    logic                                  found;
    logic [OIDX_W-1:0]                     best;
    logic                                  ufound;
    logic [UIDX_W-1:0]                     uidx;

    // Ports that give up their unit at this edge.
    always_comb begin
        port_free = '0;
        cand      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_free[p] = port_grant_q[p] &&
                (port_release[p] || !port_req[p] ||
                 (flush_valid && is_older(flush_issue_id, unit_id_q[port_unit_q[p]])));
            cand[p] = port_req[p] && !port_grant_q[p] && !port_release[p] &&
                      !(flush_valid && is_older(flush_issue_id, port_issue_id[p]));
        end
        unit_free = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_free[u] = unit_locked_q[u] && port_free[unit_owner_q[u]];
        end
    end

    // Allocation: on each pass, pick the oldest remaining candidate and give it the
    // lowest free unit. Only units that were free before this edge count (no bypass).
    always_comb begin
        avail        = ~unit_locked_q;
        remaining    = cand;
        alloc_port   = '0;
        alloc_unit   = '0;
        unit_alloc   = '0;
        unit_owner_d = unit_owner_q;
        unit_id_d    = unit_id_q;
        found        = 1'b0;
        best         = '0;
        ufound       = 1'b0;
        uidx         = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            found = 1'b0;
            best  = '0;
            // Scanning in ascending index order leaves ties with the lower port index.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (remaining[p]) begin
                    if (!found ||
                        (is_older(port_issue_id[p], port_issue_id[best]) &&
                         !is_older(port_issue_id[best], port_issue_id[p]))) begin
                        found = 1'b1;
                        best  = OIDX_W'(p);
                    end
                end
            end
            ufound = 1'b0;
            uidx   = '0;
            for (int u = NUM_UNITS - 1; u >= 0; u--) begin
                if (avail[u]) begin
                    ufound = 1'b1;
                    uidx   = UIDX_W'(u);
                end
            end
            if (found && ufound) begin
                alloc_port[best]   = 1'b1;
                alloc_unit[best]   = uidx;
                remaining[best]    = 1'b0;
                avail[uidx]        = 1'b0;
                unit_alloc[uidx]   = 1'b1;
                unit_owner_d[uidx] = best;
                unit_id_d[uidx]    = port_issue_id[best];
            end
        end
    end

    always_comb begin
        unit_locked_d = (unit_locked_q & ~unit_free) | unit_alloc;
        port_grant_d  = (port_grant_q & ~port_free) | alloc_port;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (alloc_port[p]) begin
                port_unit_d[p] = alloc_unit[p];
            end else if (port_free[p]) begin
                port_unit_d[p] = '0;
            end else begin
                port_unit_d[p] = port_unit_q[p];
            end
        end
        busy_count_d = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            busy_count_d = busy_count_d + CNT_W'(unit_locked_d[u]);
        end
        lock_error_d = lock_error_q | (|(port_release & ~port_grant_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_locked_q <= '0;
            unit_owner_q  <= '0;
            unit_id_q     <= '0;
            port_grant_q  <= '0;
            port_unit_q   <= '0;
            busy_count_q  <= '0;
            lock_error_q  <= 1'b0;
        end else begin
            unit_locked_q <= unit_locked_d;
            unit_owner_q  <= unit_owner_d;
            unit_id_q     <= unit_id_d;
            port_grant_q  <= port_grant_d;
            port_unit_q   <= port_unit_d;
            busy_count_q  <= busy_count_d;
            lock_error_q  <= lock_error_d;
        end
    end

    assign port_grant = port_grant_q;
    assign port_unit  = port_unit_q;
    assign busy_count = busy_count_q;
    assign lock_error = lock_error_q;

endmodule

// File: doc/issue_ordered_resource_pool.md
Name: issue_ordered_resource_pool

Overview:
Parametrised lock-based allocator that shares NUM_UNITS identical execution resources (ALUs, multipliers, memory lanes) among NUM_PORTS SIC request ports. It is the generalised successor to the per-resource lock pools in the superscalar machine. New capabilities are:
- age-ordered arbitration by issue ID with wrap-around;
- multi-grant per cycle;
- rollback flush of speculative owners;
- occupancy and error reporting.
Sits between the SIC array and any pooled resource; the datapath mux is external and driven by port_unit.

Parameters:
NUM_PORTS, 2, number of requesting SIC ports (>=1)
NUM_UNITS, 4, number of pooled units (>=1)
ID_WIDTH, 16, issue-ID width; IDs compared modulo 2^ID_WIDTH
UIDX_W, max(1,$clog2(NUM_UNITS)), unit-index width (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  reset
port_req  in  [NUM_PORTS]  request/hold a unit; level-sensitive
port_issue_id  in  [NUM_PORTS][ID_WIDTH]  issue ID of requester; stable while port_req high
port_release  in  [NUM_PORTS]  single-cycle pulse: free the owned unit
flush_valid  in  1  rollback pulse
flush_issue_id  in  ID_WIDTH  boundary ID; owners/requesters strictly younger are killed
port_grant  out  [NUM_PORTS]  port currently owns a unit
port_unit  out  [NUM_PORTS][UIDX_W]  index of owned unit (valid when port_grant)
busy_count  out  $clog2(NUM_UNITS+1)  number of locked units
lock_error  out  1  sticky: release from a non-owning port

Interface:
- Single clock domain: clk, all state on its rising edge.
- rst_n is asynchronous assert, active-low.
- Outputs are registered.

Behaviour:
- Reset (rst_n=0, async):
  - all units FREE;
  - port_grant=0, port_unit=0, busy_count=0, lock_error=0.
- Per-unit state: FREE / LOCKED, with owner port index and owner ID registers.
- Age compare: A older than B iff MSB of (A−B mod 2^ID_WIDTH) = 1. Ties resolve to the lower port index.
- Candidates at an edge: ports with port_req=1, port_grant=0, no release this cycle, and not killed by flush.
- Allocation:
  - Candidates are sorted oldest-first.
  - The k-th oldest candidate gets the k-th lowest-index FREE unit.
  - Allocation continues until units or candidates are exhausted.
  - Unallocated candidates retry every cycle; there is no queueing state beyond the request level.
- Latency: request sampled at edge E → port_grant/port_unit visible after E (1 cycle).
- Hold: the grant persists while port_req=1 and no release/flush. port_unit is constant while granted.
- Release:
  - port_release=1 at edge E frees the unit at E; port_grant=0 after E.
  - Dropping port_req while granted acts as a release.
  - A unit freed at E is not reallocated at E (no bypass); it is allocatable from E+1.
- Release and req both high on the same port, same cycle: release wins. The port re-arbitrates as a candidate from the next edge.
- Release from a port with port_grant=0: ignored; lock_error←1 (sticky until reset).
- Flush (flush_valid=1 at E):
  - Every LOCKED unit whose owner ID is strictly younger than flush_issue_id is freed at E.
  - Requests with younger IDs are excluded from allocation at E.
  - Owner ID equal to flush_issue_id is kept.
  - Flush and release on the same unit: single free, no error.
- busy_count equals the number of LOCKED units after each edge; it never exceeds NUM_UNITS.
- Invariants:
  - one unit per port;
  - no unit with two owners;
  - starvation-free, since the oldest pending ID always allocates first once any unit is free.
- A mid-operation reset clears all locks immediately (asynchronously); no grant survives.

Test Plan:
1. Reset with port_req=all 1 held → port_grant=0, busy_count=0 during reset; after release of reset, grants appear 1 cycle after first sampled edge.
2. NUM_UNITS=4, port0 id=5, port1 id=3 request at E → after E: port1 grant unit0, port0 grant unit1, busy_count=2.
3. NUM_UNITS=1, port0 id=10, port1 id=9 → port1 granted; port1 release pulse at E → port1 grant=0 after E, port0 grant after E+1, port_unit=0.
4. Wrap-around, NUM_UNITS=1: port0 id=0x0001, port1 id=0xFFFE simultaneous → port1 (0xFFFE, older) granted.
5. Owners port0 id=8, port1 id=6; flush_valid with flush_issue_id=7 → port0 grant=0 next cycle, port1 retained, busy_count 2→1; port0 re-requests with id 8 and is regranted 1 cycle after flush_valid drops.
6. port1 release pulse with port_grant[1]=0 → lock_error=1 and remains 1 across 10 cycles; other grants unaffected; cleared only by rst_n=0.
